// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants and bank-state encoding shared by the JPEG quantiser,
// the zig-zag buffer controller and the zig-zag address ROM.
package jpeg_pkg;

    localparam int BLK_SIZE = 64;
    localparam int IDX_W    = 6;
    localparam int COEF_W   = 12;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // A bank can take writes until its closing coefficient has landed
    function automatic logic bank_writable(input bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/zigzag_rom.sv
// zigzag_rom: combinational map from zig-zag position k (0..63) to the
// raster address row*8+col of an 8x8 block. No state; usable by an
// inverse zig-zag stage as well.
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [IDX_W-1:0] i_k,
    output logic [IDX_W-1:0] o_addr
);

    localparam int ZZ_TAB [BLK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // Table lookup: zig-zag position to raster address
    always_comb o_addr = IDX_W'(ZZ_TAB[i_k]);

endmodule

// File: rtl/zigzag_buffer.sv
// zigzag_buffer: ping-pong 8x8 block buffer. One bank fills in raster
// order (any address order, closed by address 63) while the other drains
// in JPEG zig-zag order over a valid/ready stream.
// Optional feature: define ZZ_DC_DIFF_EN to emit the idx-0 word as the
// DC difference to the previous block's DC (wrapped to DW bits).
module zigzag_buffer
    import jpeg_pkg::*;
#(
    parameter int DW = COEF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_addr,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

    bank_state_t      r_bstate     [2];
    bank_state_t      w_bstate_nxt [2];
    logic             r_wbank;
    logic             r_rbank;
    logic [IDX_W:0]   r_k;

    logic [DW-1:0]    r_mem [2*BLK_SIZE];

    logic             r_vld_p1;
    logic [IDX_W-1:0] r_idx_p1;
    logic [DW-1:0]    r_rdata_p1;

    logic             r_vld_p2;
    logic [IDX_W-1:0] r_idx_p2;
    logic [DW-1:0]    r_data_p2;
    logic             r_last_p2;

    logic             w_wr_en;
    logic             w_wr_close;
    logic             w_xfer;
    logic             w_last_xfer;
    logic             w_out_free;
    logic             w_p1_free;
    logic             w_rd_start;
    logic             w_rd_en;
    bank_state_t      w_rd_state;
    logic [IDX_W-1:0] w_k_cur;
    logic [IDX_W-1:0] w_raddr;
    logic [DW-1:0]    w_data_p1;

    zigzag_rom u_rom (
        .i_k    (w_k_cur),
        .o_addr (w_raddr)
    );

    // Handshakes and reader issue: a read is issued whenever the RAM output
    // slot will be free next cycle, giving one word per cycle at full rate
    always_comb begin
        w_wr_en     = in_valid & in_ready;
        w_wr_close  = w_wr_en & (in_addr == LAST_IDX);
        w_xfer      = r_vld_p2 & out_ready;
        w_last_xfer = w_xfer & r_last_p2;
        w_out_free  = ~r_vld_p2 | out_ready;
        w_p1_free   = ~r_vld_p1 | w_out_free;
        w_rd_state  = r_bstate[r_rbank];
        w_rd_start  = (w_rd_state == BANK_FULL) & w_p1_free;
        w_rd_en     = w_rd_start
                    | ((w_rd_state == BANK_DRAINING) & ~r_k[IDX_W] & w_p1_free);
        w_k_cur     = w_rd_start ? '0 : r_k[IDX_W-1:0];
    end

    // Bank state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate[0] <= BANK_EMPTY;
            r_bstate[1] <= BANK_EMPTY;
        end else begin
            r_bstate[0] <= w_bstate_nxt[0];
            r_bstate[1] <= w_bstate_nxt[1];
        end
    end

    // Bank next state: the writer only touches EMPTY/FILLING banks and the
    // reader only FULL/DRAINING ones, so both sides can act in one cycle
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bstate_nxt[b] = r_bstate[b];
            if (w_wr_en && (r_wbank == 1'(b)))
                w_bstate_nxt[b] = w_wr_close ? BANK_FULL : BANK_FILLING;
            if (r_rbank == 1'(b)) begin
                if (w_rd_start)
                    w_bstate_nxt[b] = BANK_DRAINING;
                else if (w_last_xfer)
                    w_bstate_nxt[b] = BANK_EMPTY;
            end
        end
    end

    // Output decode of the bank FSM: stall the writer while its bank is busy
    always_comb in_ready = bank_writable(r_bstate[r_wbank]);

    // Bank pointers and zig-zag read counter (bit IDX_W marks all 64 issued)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_k     <= '0;
        end else begin
            if (w_wr_close)
                r_wbank <= ~r_wbank;
            if (w_last_xfer)
                r_rbank <= ~r_rbank;
            if (w_rd_en)
                r_k <= {1'b0, w_k_cur} + 1'b1;
        end
    end

    // Block storage: bank select in the address MSB, synchronous read port
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[{r_wbank, in_addr}] <= in_data;
        if (w_rd_en)
            r_rdata_p1 <= r_mem[{r_rbank, w_raddr}];
    end

    // ---- stage p1: RAM read data, held until the output register takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_idx_p1 <= '0;
        end else if (w_rd_en) begin
            r_vld_p1 <= 1'b1;
            r_idx_p1 <= w_k_cur;
        end else if (w_out_free) begin
            r_vld_p1 <= 1'b0;
        end
    end

`ifdef ZZ_DC_DIFF_EN
    logic signed [DW-1:0] r_pred;

    function automatic logic signed [DW-1:0] dc_diff(input logic signed [DW-1:0] dc,
                                                     input logic signed [DW-1:0] pred);
        return dc - pred;
    endfunction

    function automatic logic signed [DW-1:0] dc_restore(input logic signed [DW-1:0] diff,
                                                        input logic signed [DW-1:0] pred);
        return diff + pred;
    endfunction

    // DC term leaves as a difference; every other index passes raw
    always_comb w_data_p1 = (r_idx_p1 == '0) ? dc_diff(r_rdata_p1, r_pred) : r_rdata_p1;

    // Predictor recovers the raw DC from the difference as the idx-0 word leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pred <= '0;
        else if (w_xfer && (r_idx_p2 == '0))
            r_pred <= dc_restore(r_data_p2, r_pred);
    end
`else
    // Raw coefficient at every index
    always_comb w_data_p1 = r_rdata_p1;
`endif

    // ---- stage p2: output register, frozen while out_valid & !out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_idx_p2  <= '0;
            r_last_p2 <= 1'b0;
        end else if (w_out_free) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_data_p1;
                r_idx_p2  <= r_idx_p1;
                r_last_p2 <= (r_idx_p1 == LAST_IDX);
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_idx   = r_idx_p2;
    assign out_last  = r_last_p2;

endmodule
